// File: rtl/decoder_xx6812_pkg.sv
// decoder_xx6812_pkg
// Shared xx6812 line timing at 12 MHz (also used by the strip encoder and its
// bench), decoder counter width, decoder state type and a saturating
// increment helper.
package decoder_xx6812_pkg;

    // Nominal encoder timing in clock_12mhz cycles.
    localparam int T0H_CYCLES           = 5;
    localparam int T1H_CYCLES           = 10;
    localparam int BIT_PERIOD_CYCLES    = 15;
    localparam int RESET_CYCLES_DEFAULT = 600;

    // Width of the high/low pulse-width counters.
    localparam int                CNT_W   = 10;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_SYNC         = 2'd0,
        ST_IDLE         = 2'd1,
        ST_MEASURE_HIGH = 2'd2,
        ST_MEASURE_LOW  = 2'd3
    } dec_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/decoder_xx6812_sync.sv
// decoder_xx6812_sync
// Multi-flop synchronizer for an asynchronous single-wire input, followed by
// a registered copy of the synchronized level for edge detection.
// Ports:
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   i_async  asynchronous input line
//   o_level  synchronized level (s)
//   o_rise   s & ~s_prev
//   o_fall   ~s & s_prev
module decoder_xx6812_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // Fewer than two flops is not a synchronizer; clamp silently.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_chain <= '0;
            r_prev  <= 1'b0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_level = r_chain[STAGES-1];
    assign o_rise  =  r_chain[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_chain[STAGES-1] &  r_prev;

endmodule

// File: rtl/decoder_xx6812.sv
// decoder_xx6812
// Receive side of the xx6812 strip link. Classifies synchronized high pulses
// by width, assembles MSB-first LED words and detects the latch gap that
// ends a frame.
//
// state            | meaning
// -----------------+------------------------------------------------------
// ST_SYNC          | lost/unknown framing; wait for RESET_CYCLES of low
// ST_IDLE          | between frames, waiting for first rising edge
// ST_MEASURE_HIGH  | counting width of the current high pulse
// ST_MEASURE_LOW   | counting low time after a bit; long low ends frame
//
// Ports:
//   clock_12mhz        sole clock
//   reset              synchronous active-high reset
//   serial_data_in     asynchronous xx6812 line
//   parallel_data_out  last complete word, bit 23 = first received bit
//   data_valid         1-cycle pulse when word/led_index update
//   led_index          word index within current frame (wraps 255->0)
//   frame_done         1-cycle pulse at latch-gap detection
//   error              1-cycle pulse on glitch, stuck-high or partial word
//   busy               high while inside a frame
module decoder_xx6812
    import decoder_xx6812_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int MIN_HIGH_CYCLES  = 2,
    parameter int THRESHOLD_CYCLES = 7,
    parameter int MAX_HIGH_CYCLES  = 14,
    parameter int RESET_CYCLES     = RESET_CYCLES_DEFAULT,
    parameter int BITS_PER_LED     = 24
) (
    input  logic                    clock_12mhz,
    input  logic                    reset,
    input  logic                    serial_data_in,
    output logic [BITS_PER_LED-1:0] parallel_data_out,
    output logic                    data_valid,
    output logic [7:0]              led_index,
    output logic                    frame_done,
    output logic                    error,
    output logic                    busy
);

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] THR_C   = CNT_W'(THRESHOLD_CYCLES);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_HIGH_CYCLES);
    localparam logic [CNT_W-1:0] RESET_C = CNT_W'(RESET_CYCLES);
    localparam logic [4:0]       BITS_C  = 5'(BITS_PER_LED);

    logic w_s, w_rise, w_fall;

    dec_state_t r_state, w_state_next;

    logic [CNT_W-1:0]        r_high_count, w_high_next, w_high_inc;
    logic [CNT_W-1:0]        r_low_count,  w_low_next,  w_low_inc;
    logic [BITS_PER_LED-1:0] r_shift, w_shift_next, w_word;
    logic [4:0]              r_bit_count, w_bit_next, w_bit_inc;
    logic [7:0]              r_word_count;
    logic                    w_bit_value;
    logic                    w_word_done, w_frame_done, w_error;

    logic [BITS_PER_LED-1:0] r_parallel;
    logic [7:0]              r_led_index;
    logic                    r_data_valid, r_frame_done, r_error;

    decoder_xx6812_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clock_12mhz),
        .i_reset (reset),
        .i_async (serial_data_in),
        .o_level (w_s),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_high_inc  = sat_inc(r_high_count);
    assign w_low_inc   = sat_inc(r_low_count);
    assign w_bit_inc   = r_bit_count + 5'd1;
    assign w_bit_value = (r_high_count >= THR_C);
    assign w_word      = {r_shift[BITS_PER_LED-2:0], w_bit_value};

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_high_next  = r_high_count;
        w_low_next   = r_low_count;
        w_shift_next = r_shift;
        w_bit_next   = r_bit_count;
        w_word_done  = 1'b0;
        w_frame_done = 1'b0;
        w_error      = 1'b0;

        case (r_state)
            ST_SYNC: begin
                // Any high level restarts the gap measurement.
                if (w_s) begin
                    w_low_next = '0;
                end else if (r_low_count >= RESET_C) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_low_next = w_low_inc;
                end
            end

            ST_IDLE: begin
                if (w_rise) begin
                    w_high_next  = CNT_W'(1);
                    w_state_next = ST_MEASURE_HIGH;
                end
            end

            ST_MEASURE_HIGH: begin
                if (w_fall) begin
                    if (r_high_count < MIN_C) begin
                        w_error      = 1'b1;
                        w_shift_next = '0;
                        w_bit_next   = '0;
                        w_low_next   = '0;
                        w_state_next = ST_SYNC;
                    end else begin
                        // Completion is flagged at the shift edge so the
                        // word appears on the output one cycle later.
                        w_shift_next = w_word;
                        w_low_next   = CNT_W'(1);
                        w_state_next = ST_MEASURE_LOW;
                        if (w_bit_inc == BITS_C) begin
                            w_word_done = 1'b1;
                            w_bit_next  = '0;
                        end else begin
                            w_bit_next  = w_bit_inc;
                        end
                    end
                end else if (r_high_count >= MAX_C) begin
                    // Still high with MAX already counted: pulse is too long.
                    w_error      = 1'b1;
                    w_shift_next = '0;
                    w_bit_next   = '0;
                    w_low_next   = '0;
                    w_state_next = ST_SYNC;
                end else begin
                    w_high_next = w_high_inc;
                end
            end

            ST_MEASURE_LOW: begin
                if (w_rise) begin
                    w_high_next  = CNT_W'(1);
                    w_state_next = ST_MEASURE_HIGH;
                end else if (w_low_inc >= RESET_C) begin
                    w_frame_done = 1'b1;
                    w_error      = (r_bit_count != 5'd0);
                    w_shift_next = '0;
                    w_bit_next   = '0;
                    w_low_next   = w_low_inc;
                    w_state_next = ST_IDLE;
                end else begin
                    w_low_next = w_low_inc;
                end
            end

            default: begin
                w_state_next = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clock_12mhz) begin
        if (reset) begin
            r_high_count <= '0;
            r_low_count  <= '0;
            r_shift      <= '0;
            r_bit_count  <= '0;
            r_word_count <= '0;
            r_parallel   <= '0;
            r_led_index  <= '0;
            r_data_valid <= 1'b0;
            r_frame_done <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_high_count <= w_high_next;
            r_low_count  <= w_low_next;
            r_shift      <= w_shift_next;
            r_bit_count  <= w_bit_next;
            r_data_valid <= w_word_done;
            r_frame_done <= w_frame_done;
            r_error      <= w_error;
            if (w_word_done) begin
                r_parallel   <= w_word;
                r_led_index  <= r_word_count;
                r_word_count <= r_word_count + 8'd1;
            end else if (w_frame_done) begin
                r_word_count <= '0;
            end
        end
    end

    assign parallel_data_out = r_parallel;
    assign led_index         = r_led_index;
    assign data_valid        = r_data_valid;
    assign frame_done        = r_frame_done;
    assign error             = r_error;
    assign busy              = (r_state == ST_MEASURE_HIGH) || (r_state == ST_MEASURE_LOW);

endmodule

// File: tb/tb_decoder_xx6812.sv
module tb_decoder_xx6812;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_HIGH    = 14;
    localparam int GAP         = 700;

    logic        clk = 1'b0;
    logic        reset;
    logic        serial;
    logic [23:0] parallel_data_out;
    logic        data_valid;
    logic [7:0]  led_index;
    logic        frame_done;
    logic        error;
    logic        busy;

    always #5 clk = ~clk;

    decoder_xx6812 dut (
        .clock_12mhz       (clk),
        .reset             (reset),
        .serial_data_in    (serial),
        .parallel_data_out (parallel_data_out),
        .data_valid        (data_valid),
        .led_index         (led_index),
        .frame_done        (frame_done),
        .error             (error),
        .busy              (busy)
    );

    typedef struct packed {
        logic [23:0] word;
        logic [7:0]  idx;
    } exp_t;

    typedef struct {
        logic [23:0] word;
        int          h0;
        int          h1;
        bit          gap;
        logic [7:0]  idx;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    int n_dv = 0, n_fd = 0, n_err = 0, n_fd_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic expect_word(input logic [23:0] w, input logic [7:0] idx);
        exp_t e;
        e.word = w;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input int h0, input int h1);
        int hi;
        hi = b ? h1 : h0;
        serial = 1'b1;
        repeat (hi) @(negedge clk);
        serial = 1'b0;
        repeat (15 - hi) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w, input int h0, input int h1);
        for (int i = 23; i >= 0; i--) send_bit(w[i], h0, h1);
    endtask

    task automatic gap(input int n);
        serial = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every data_valid pops one expected word.
    always @(negedge clk) begin
        if (data_valid) begin
            n_dv++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dv got %0h idx %0d expected no word", parallel_data_out, led_index);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dv_word", 32'(parallel_data_out), 32'(e.word));
                chk("dv_idx", 32'(led_index), 32'(e.idx));
            end
        end
        if (frame_done) n_fd++;
        if (error) n_err++;
        if (frame_done && error) n_fd_err++;
    end

    initial begin
        #(80000 * 10);
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int frames, fd0, err0, dv0, fe0, lat, seen, stuck_at;
        logic [23:0] lw;

        vecs[0] = '{24'hA53CF0, 5, 10, 1'b1, 8'd0};
        vecs[1] = '{24'hFF0000, 5, 10, 1'b0, 8'd0};
        vecs[2] = '{24'h00FF00, 5, 10, 1'b0, 8'd1};
        vecs[3] = '{24'h0000FF, 5, 10, 1'b1, 8'd2};
        vecs[4] = '{24'hAAAAAA, 6,  7, 1'b1, 8'd0};
        vecs[5] = '{24'h5A5A5A, 2, 14, 1'b1, 8'd0};
        vecs[6] = '{24'h123456, 5, 10, 1'b0, 8'd0};
        vecs[7] = '{24'h800001, 5, 10, 1'b1, 8'd1};

        serial = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_word", 32'(parallel_data_out), 32'h0);
        chk("rst_idx", 32'(led_index), 32'h0);
        chk("rst_dv", 32'(data_valid), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_err", 32'(error), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        gap(GAP);
        chk("sync_no_fd", 32'(n_fd), 32'h0);

        // Table-driven frames.
        fd0 = n_fd;
        frames = 0;
        for (int i = 0; i < 8; i++) begin
            expect_word(vecs[i].word, vecs[i].idx);
            send_word(vecs[i].word, vecs[i].h0, vecs[i].h1);
            if (vecs[i].gap) begin
                gap(GAP);
                frames++;
                chk("table_fd", 32'(n_fd), 32'(fd0 + frames));
            end
        end
        chk("table_err", 32'(n_err), 32'h0);
        chk("hold_word", 32'(parallel_data_out), 32'h800001);
        chk("hold_idx", 32'(led_index), 32'h1);
        chk("idle_busy", 32'(busy), 32'h0);

        // Latency from raw fall of the last bit to data_valid.
        lw = 24'hC0FFEE;
        expect_word(lw, 8'd0);
        for (int i = 23; i >= 1; i--) send_bit(lw[i], 5, 10);
        serial = 1'b1;
        repeat (5) @(negedge clk);
        serial = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (data_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(SYNC_STAGES + 1));
        gap(GAP);

        // One-cycle glitch mid-word.
        err0 = n_err; dv0 = n_dv; fd0 = n_fd;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 5, 10);
        serial = 1'b1;
        @(negedge clk);
        serial = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (error) seen = 1;
        end
        chk("glitch_err", 32'(seen), 32'h1);
        chk("glitch_busy", 32'(busy), 32'h0);
        send_word(24'h777777, 5, 10);
        gap(GAP);
        chk("glitch_err_cnt", 32'(n_err), 32'(err0 + 1));
        chk("glitch_no_dv", 32'(n_dv), 32'(dv0));
        chk("glitch_no_fd", 32'(n_fd), 32'(fd0));
        expect_word(24'h0F0F0F, 8'd0);
        send_word(24'h0F0F0F, 5, 10);
        gap(GAP);

        // Stuck-high mid-word.
        err0 = n_err;
        for (int i = 0; i < 4; i++) send_bit(1'b0, 5, 10);
        serial = 1'b1;
        stuck_at = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (error) begin
                stuck_at = k;
                break;
            end
        end
        chk("stuck_cycle", 32'(stuck_at), 32'(SYNC_STAGES + MAX_HIGH + 1));
        chk("stuck_busy", 32'(busy), 32'h0);
        repeat (4) @(negedge clk);
        gap(GAP);
        chk("stuck_err_cnt", 32'(n_err), 32'(err0 + 1));

        // Partial word terminated by the gap.
        err0 = n_err; dv0 = n_dv; fd0 = n_fd; fe0 = n_fd_err;
        for (int i = 0; i < 12; i++) send_bit(i[0], 5, 10);
        gap(GAP);
        chk("partial_fd", 32'(n_fd), 32'(fd0 + 1));
        chk("partial_err", 32'(n_err), 32'(err0 + 1));
        chk("partial_same_cycle", 32'(n_fd_err), 32'(fe0 + 1));
        chk("partial_no_dv", 32'(n_dv), 32'(dv0));
        expect_word(24'h13579B, 8'd0);
        send_word(24'h13579B, 5, 10);
        gap(GAP);

        // Reset mid-frame.
        for (int i = 0; i < 10; i++) send_bit(1'b1, 5, 10);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_word", 32'(parallel_data_out), 32'h0);
        chk("mid_rst_idx", 32'(led_index), 32'h0);
        chk("mid_rst_dv", 32'(data_valid), 32'h0);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        chk("mid_rst_err", 32'(error), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        dv0 = n_dv;
        send_word(24'hDEAD00, 5, 10);
        gap(GAP);
        chk("rst_ignored", 32'(n_dv), 32'(dv0));
        expect_word(24'h2468AC, 8'd0);
        send_word(24'h2468AC, 5, 10);
        gap(GAP);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        chk("total_dv", 32'(n_dv), 32'd12);
        chk("total_err", 32'(n_err), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
